// File: rtl/ls_queue.sv
// ls_queue: in-order load/store queue.
//
// Entries are dispatched at the tail. Each entry holds an opcode, two
// operands (v1/v2), an immediate, the two producer tags (q1/q2) and its
// ROB tag. Operands are captured from two CDB ports, either on dispatch
// (bypass) or while the entry waits. Only the head may issue. A load
// issues once its operands are ready. A store first asks the ROB for
// commit through st_req, and it issues only after the commit arrives.
// A mispredict flush keeps only the committed stores at the head.
//
// Ports
//   clk, rst           sole clock, synchronous active-high reset
//   rdy                global enable; when low all state holds
//   dsp_*              dispatch request (op, v1, v2, imm, q1, q2, rob)
//   full, almost_full  occupancy flags; count = number of valid entries
//   ex_*               registered issue channel (ex_ready is backpressure)
//   cdb0_*, cdb1_*     result broadcasts; cdb0 wins when both match
//   commit_valid/rob   ROB commit notification
//   st_req_valid/rob   one-shot commit request for an operand-ready head store
//   flush              mispredict flush
module ls_queue #(
    parameter int DEPTH    = 16,
    parameter int ROB_W    = 4,
    parameter int DATA_W   = 32,
    parameter int OP_W     = 4,
    parameter int ST_BASE  = 5,
    parameter int AF_SLACK = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    dsp_valid,
    input  logic [OP_W-1:0]         dsp_op,
    input  logic [DATA_W-1:0]       dsp_v1,
    input  logic [DATA_W-1:0]       dsp_v2,
    input  logic [DATA_W-1:0]       dsp_imm,
    input  logic [ROB_W-1:0]        dsp_q1,
    input  logic [ROB_W-1:0]        dsp_q2,
    input  logic [ROB_W-1:0]        dsp_rob,
    output logic                    full,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    ex_valid,
    output logic [OP_W-1:0]         ex_op,
    output logic [DATA_W-1:0]       ex_addr,
    output logic [DATA_W-1:0]       ex_wdata,
    output logic [ROB_W-1:0]        ex_rob,
    input  logic                    ex_ready,
    input  logic                    cdb0_valid,
    input  logic [ROB_W-1:0]        cdb0_rob,
    input  logic [DATA_W-1:0]       cdb0_data,
    input  logic                    cdb1_valid,
    input  logic [ROB_W-1:0]        cdb1_rob,
    input  logic [DATA_W-1:0]       cdb1_data,
    input  logic                    commit_valid,
    input  logic [ROB_W-1:0]        commit_rob,
    output logic                    st_req_valid,
    output logic [ROB_W-1:0]        st_req_rob,
    input  logic                    flush
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    function automatic logic is_store(input logic [OP_W-1:0] o);
        return o >= OP_W'(ST_BASE);
    endfunction

    // Queue control state (reset) and payload (not reset).
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  cnt;
    logic [DEPTH-1:0]  busy, cmt, req_sent;
    logic [ROB_W-1:0]  q1  [DEPTH];
    logic [ROB_W-1:0]  q2  [DEPTH];
    logic [DATA_W-1:0] v1  [DEPTH];
    logic [DATA_W-1:0] v2  [DEPTH];
    logic [DATA_W-1:0] imm [DEPTH];
    logic [OP_W-1:0]   op  [DEPTH];
    logic [ROB_W-1:0]  tag [DEPTH];

    logic ex_valid_q, st_req_q;

    // ------------------------------------------------------------------
    // CDB wakeup of waiting entries.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]  wake1, wake2;
    logic [DATA_W-1:0] wake1_data [DEPTH];
    logic [DATA_W-1:0] wake2_data [DEPTH];

    // NOTE: every signal written in this always_comb gets a default before
    // any condition, so no path can leave it unassigned and infer a latch.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i]      = 1'b0;
            wake2[i]      = 1'b0;
            wake1_data[i] = '0;
            wake2_data[i] = '0;
            if (busy[i] && q1[i] != '0) begin
                if (cdb0_valid && cdb0_rob == q1[i]) begin
                    wake1[i]      = 1'b1;
                    wake1_data[i] = cdb0_data;
                end else if (cdb1_valid && cdb1_rob == q1[i]) begin
                    wake1[i]      = 1'b1;
                    wake1_data[i] = cdb1_data;
                end
            end
            if (busy[i] && q2[i] != '0) begin
                if (cdb0_valid && cdb0_rob == q2[i]) begin
                    wake2[i]      = 1'b1;
                    wake2_data[i] = cdb0_data;
                end else if (cdb1_valid && cdb1_rob == q2[i]) begin
                    wake2[i]      = 1'b1;
                    wake2_data[i] = cdb1_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Dispatch bypass: a result broadcast in the dispatch cycle would
    // otherwise be missed, because the entry is not busy yet.
    // ------------------------------------------------------------------
    logic [ROB_W-1:0]  ins_q1, ins_q2;
    logic [DATA_W-1:0] ins_v1, ins_v2;

    always_comb begin
        ins_q1 = dsp_q1;
        ins_v1 = dsp_v1;
        ins_q2 = dsp_q2;
        ins_v2 = dsp_v2;
        if (dsp_q1 != '0) begin
            if (cdb0_valid && cdb0_rob == dsp_q1) begin
                ins_q1 = '0;
                ins_v1 = cdb0_data;
            end else if (cdb1_valid && cdb1_rob == dsp_q1) begin
                ins_q1 = '0;
                ins_v1 = cdb1_data;
            end
        end
        if (dsp_q2 != '0) begin
            if (cdb0_valid && cdb0_rob == dsp_q2) begin
                ins_q2 = '0;
                ins_v2 = cdb0_data;
            end else if (cdb1_valid && cdb1_rob == dsp_q2) begin
                ins_q2 = '0;
                ins_v2 = cdb1_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Flush survivors: the unbroken run of committed stores starting at
    // the head. Everything from the first non-survivor onwards is dropped.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] keep;
    logic [CNT_W-1:0] keep_cnt;
    logic             run;
    logic [PTR_W-1:0] idx;

    always_comb begin
        keep     = '0;
        keep_cnt = '0;
        run      = 1'b1;
        idx      = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            run = run && (CNT_W'(i) < cnt) && busy[idx] && cmt[idx]
                  && is_store(op[idx]);
            if (run) begin
                keep[idx] = 1'b1;
                keep_cnt  = keep_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Head decisions.
    // ------------------------------------------------------------------
    logic head_rdy, head_st, do_issue, do_streq, do_insert;

    assign full        = (cnt == CNT_W'(DEPTH));
    assign almost_full = (cnt >= CNT_W'(DEPTH - AF_SLACK));
    assign count       = cnt;

    assign head_rdy  = busy[head] && q1[head] == '0 && q2[head] == '0;
    assign head_st   = is_store(op[head]);
    assign do_issue  = rdy && !flush && head_rdy && ex_ready
                       && (!head_st || cmt[head]);
    assign do_streq  = rdy && !flush && head_rdy && head_st
                       && !cmt[head] && !req_sent[head];
    assign do_insert = rdy && !flush && dsp_valid && !full;

    // The pulse flops keep their value while rdy is low. Gating them here
    // delays a pending pulse until rdy returns, so it is never lost.
    assign ex_valid     = ex_valid_q && rdy;
    assign st_req_valid = st_req_q && rdy;

    // ------------------------------------------------------------------
    // Control state.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. Every read in
    // this block sees the values from before the edge. When several
    // statements write the same bit, the last one wins (flush comes last).
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            cnt        <= '0;
            busy       <= '0;
            cmt        <= '0;
            req_sent   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q1[i] <= '0;
                q2[i] <= '0;
            end
            ex_valid_q <= 1'b0;
            st_req_q   <= 1'b0;
            st_req_rob <= '0;
            ex_op      <= '0;
            ex_addr    <= '0;
            ex_wdata   <= '0;
            ex_rob     <= '0;
        end else if (rdy) begin
            ex_valid_q <= do_issue;
            st_req_q   <= do_streq;

            for (int i = 0; i < DEPTH; i++) begin
                if (wake1[i]) q1[i] <= '0;
                if (wake2[i]) q2[i] <= '0;
                if (busy[i] && commit_valid && tag[i] == commit_rob)
                    cmt[i] <= 1'b1;
            end

            if (do_streq) begin
                st_req_rob     <= tag[head];
                req_sent[head] <= 1'b1;
            end

            if (do_issue) begin
                ex_op      <= op[head];
                ex_addr    <= v1[head] + imm[head];
                ex_wdata   <= v2[head];
                ex_rob     <= tag[head];
                busy[head] <= 1'b0;
                head       <= head + PTR_W'(1);
            end

            if (do_insert) begin
                busy[tail]     <= 1'b1;
                cmt[tail]      <= 1'b0;
                req_sent[tail] <= 1'b0;
                q1[tail]       <= ins_q1;
                q2[tail]       <= ins_q2;
                tail           <= tail + PTR_W'(1);
            end

            case ({do_insert, do_issue})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase

            if (flush) begin
                busy <= keep;
                tail <= head + PTR_W'(keep_cnt);
                cnt  <= keep_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Payload storage.
    // ------------------------------------------------------------------
    // NOTE: the payload arrays have no reset. An entry is only read while
    // its busy bit is set, and busy is always reset. Leaving the reset off
    // lets these arrays map onto plain storage.
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wake1[i]) v1[i] <= wake1_data[i];
                if (wake2[i]) v2[i] <= wake2_data[i];
            end
            if (do_insert) begin
                op[tail]  <= dsp_op;
                v1[tail]  <= ins_v1;
                v2[tail]  <= ins_v2;
                imm[tail] <= dsp_imm;
                tag[tail] <= dsp_rob;
            end
        end
    end

endmodule

// File: tb/tb_ls_queue.sv
// tb_ls_queue: self-checking bench for ls_queue. Stimulus pushes the
// expected issue and st_req transactions into queues. A negedge monitor
// pops and compares them whenever the DUT presents ex_valid or
// st_req_valid.
module tb_ls_queue;

    localparam int DEPTH  = 16;
    localparam int ROB_W  = 4;
    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst, rdy, flush;
    logic              dsp_valid;
    logic [OP_W-1:0]   dsp_op;
    logic [DATA_W-1:0] dsp_v1, dsp_v2, dsp_imm;
    logic [ROB_W-1:0]  dsp_q1, dsp_q2, dsp_rob;
    logic              full, almost_full;
    logic [CNT_W-1:0]  count;
    logic              ex_valid, ex_ready;
    logic [OP_W-1:0]   ex_op;
    logic [DATA_W-1:0] ex_addr, ex_wdata;
    logic [ROB_W-1:0]  ex_rob;
    logic              cdb0_valid, cdb1_valid;
    logic [ROB_W-1:0]  cdb0_rob, cdb1_rob;
    logic [DATA_W-1:0] cdb0_data, cdb1_data;
    logic              commit_valid;
    logic [ROB_W-1:0]  commit_rob;
    logic              st_req_valid;
    logic [ROB_W-1:0]  st_req_rob;

    always #5 clk = ~clk;

    ls_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .DATA_W(DATA_W), .OP_W(OP_W),
               .ST_BASE(5), .AF_SLACK(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .dsp_valid(dsp_valid), .dsp_op(dsp_op), .dsp_v1(dsp_v1),
        .dsp_v2(dsp_v2), .dsp_imm(dsp_imm), .dsp_q1(dsp_q1),
        .dsp_q2(dsp_q2), .dsp_rob(dsp_rob),
        .full(full), .almost_full(almost_full), .count(count),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .ex_rob(ex_rob), .ex_ready(ex_ready),
        .cdb0_valid(cdb0_valid), .cdb0_rob(cdb0_rob), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_rob(cdb1_rob), .cdb1_data(cdb1_data),
        .commit_valid(commit_valid), .commit_rob(commit_rob),
        .st_req_valid(st_req_valid), .st_req_rob(st_req_rob),
        .flush(flush)
    );

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              chk_w;
        logic [ROB_W-1:0]  rob;
    } ex_t;

    ex_t              exq[$];
    logic [ROB_W-1:0] stq[$];
    int               checks   = 0;
    int               failures = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ex(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata, input logic chk_w,
                             input logic [ROB_W-1:0] rob);
        ex_t e;
        e.op = op; e.addr = addr; e.wdata = wdata; e.chk_w = chk_w; e.rob = rob;
        exq.push_back(e);
    endtask

    task automatic dispatch(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] v1,
                            input logic [DATA_W-1:0] v2, input logic [DATA_W-1:0] imm,
                            input logic [ROB_W-1:0] q1, input logic [ROB_W-1:0] q2,
                            input logic [ROB_W-1:0] rob);
        dsp_op = op; dsp_v1 = v1; dsp_v2 = v2; dsp_imm = imm;
        dsp_q1 = q1; dsp_q2 = q2; dsp_rob = rob;
        dsp_valid = 1'b1;
        step();
        dsp_valid = 1'b0;
        dsp_q1 = '0;
        dsp_q2 = '0;
    endtask

    // Monitor: every presented transaction must match the oldest expectation.
    always @(negedge clk) begin
        if (ex_valid === 1'b1) begin
            if (exq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ex_unexpected: got ex_valid rob=%0h addr=%0h expected none",
                         ex_rob, ex_addr);
            end else begin
                ex_t e;
                e = exq.pop_front();
                check("ex_op", 64'(ex_op), 64'(e.op));
                check("ex_addr", 64'(ex_addr), 64'(e.addr));
                if (e.chk_w) check("ex_wdata", 64'(ex_wdata), 64'(e.wdata));
                check("ex_rob", 64'(ex_rob), 64'(e.rob));
            end
        end
        if (st_req_valid === 1'b1) begin
            if (stq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL st_req_unexpected: got st_req rob=%0h expected none",
                         st_req_rob);
            end else begin
                logic [ROB_W-1:0] r;
                r = stq.pop_front();
                check("st_req_rob", 64'(st_req_rob), 64'(r));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; ex_ready = 1'b0;
        dsp_valid = 1'b0; dsp_op = '0; dsp_v1 = '0; dsp_v2 = '0; dsp_imm = '0;
        dsp_q1 = '0; dsp_q2 = '0; dsp_rob = '0;
        cdb0_valid = 1'b0; cdb0_rob = '0; cdb0_data = '0;
        cdb1_valid = 1'b0; cdb1_rob = '0; cdb1_data = '0;
        commit_valid = 1'b0; commit_rob = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state.
        check("rst_count", 64'(count), 0);
        check("rst_full", 64'(full), 0);
        check("rst_af", 64'(almost_full), 0);
        check("rst_ex_valid", 64'(ex_valid), 0);
        check("rst_st_req_valid", 64'(st_req_valid), 0);
        check("rst_ex_rob", 64'(ex_rob), 0);
        check("rst_st_req_rob", 64'(st_req_rob), 0);

        // Simple load: 0x100 + 4, issued the cycle after insert.
        ex_ready = 1'b1;
        expect_ex(4'd1, 32'h104, '0, 1'b0, 4'd1);
        dispatch(4'd1, 32'h100, 32'h0, 32'h4, 4'd0, 4'd0, 4'd1);
        check("load_count_after_insert", 64'(count), 1);
        step();
        check("load_count_after_issue", 64'(count), 0);
        step();

        // Fill to DEPTH with ex_ready low, then drop one extra dispatch.
        ex_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            expect_ex(4'd2, DATA_W'(i * 16 + i), '0, 1'b0, ROB_W'(i % 15 + 1));
            dispatch(4'd2, DATA_W'(i * 16), 32'h0, DATA_W'(i), 4'd0, 4'd0,
                     ROB_W'(i % 15 + 1));
            check("fill_count", 64'(count), 64'(i + 1));
            check("fill_af", 64'(almost_full), 64'((i + 1) >= DEPTH - 2));
        end
        check("fill_full", 64'(full), 1);
        dispatch(4'd3, 32'hFFF0, 32'h0, 32'h1, 4'd0, 4'd0, 4'd15);
        check("full_drop_count", 64'(count), 64'(DEPTH));
        check("full_drop_full", 64'(full), 1);
        ex_ready = 1'b1;
        n = 0;
        while (count != 0 && n < 40) begin
            step();
            n++;
        end
        check("fill_drain_count", 64'(count), 0);
        step();
        step();

        // Store waiting on q2=3, woken by cdb1, requests commit once, then issues.
        dispatch(4'd6, 32'h200, 32'h0, 32'h8, 4'd0, 4'd3, 4'd4);
        step();
        step();
        stq.push_back(4'd4);
        cdb1_valid = 1'b1; cdb1_rob = 4'd3; cdb1_data = 32'hAB;
        step();
        cdb1_valid = 1'b0;
        repeat (4) step();
        check("store_waits_commit", 64'(count), 1);
        expect_ex(4'd6, 32'h208, 32'hAB, 1'b1, 4'd4);
        commit_valid = 1'b1; commit_rob = 4'd4;
        step();
        commit_valid = 1'b0;
        step();
        step();
        check("store_issued_count", 64'(count), 0);

        // Dispatch-time bypass with both CDBs matching: cdb0 wins.
        expect_ex(4'd2, 32'h3010, '0, 1'b0, 4'd6);
        cdb0_valid = 1'b1; cdb0_rob = 4'd5; cdb0_data = 32'h3000;
        cdb1_valid = 1'b1; cdb1_rob = 4'd5; cdb1_data = 32'h9999;
        dispatch(4'd2, 32'hDEAD, 32'h0, 32'h10, 4'd5, 4'd0, 4'd6);
        cdb0_valid = 1'b0; cdb1_valid = 1'b0;
        check("bypass_count_insert", 64'(count), 1);
        step();
        check("bypass_count_issued", 64'(count), 0);
        step();

        // In-queue wakeup with both CDBs matching: cdb0 wins.
        dispatch(4'd3, 32'h0, 32'h0, 32'h1, 4'd7, 4'd0, 4'd8);
        step();
        check("wake_wait_count", 64'(count), 1);
        expect_ex(4'd3, 32'h501, '0, 1'b0, 4'd8);
        cdb0_valid = 1'b1; cdb0_rob = 4'd7; cdb0_data = 32'h500;
        cdb1_valid = 1'b1; cdb1_rob = 4'd7; cdb1_data = 32'h600;
        step();
        cdb0_valid = 1'b0; cdb1_valid = 1'b0;
        step();
        check("wake_issued_count", 64'(count), 0);
        step();

        // Flush keeps the two committed head stores, drops load and store.
        ex_ready = 1'b0;
        stq.push_back(4'd1);
        dispatch(4'd5, 32'h10, 32'h11, 32'h0, 4'd0, 4'd0, 4'd1);
        dispatch(4'd7, 32'h20, 32'h22, 32'h4, 4'd0, 4'd0, 4'd2);
        dispatch(4'd1, 32'h30, 32'h0, 32'h0, 4'd0, 4'd0, 4'd3);
        dispatch(4'd5, 32'h40, 32'h44, 32'h0, 4'd0, 4'd0, 4'd4);
        commit_valid = 1'b1; commit_rob = 4'd1;
        step();
        commit_rob = 4'd2;
        step();
        commit_valid = 1'b0;
        check("pre_flush_count", 64'(count), 4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_keep_count", 64'(count), 2);
        expect_ex(4'd5, 32'h10, 32'h11, 1'b1, 4'd1);
        expect_ex(4'd7, 32'h24, 32'h22, 1'b1, 4'd2);
        ex_ready = 1'b1;
        repeat (4) step();
        check("flush_drain_count", 64'(count), 0);
        expect_ex(4'd1, 32'h41, '0, 1'b0, 4'd9);
        dispatch(4'd1, 32'h40, 32'h0, 32'h1, 4'd0, 4'd0, 4'd9);
        step();
        check("post_flush_count", 64'(count), 0);

        // Flush with nothing committed empties the queue and blocks dispatch.
        ex_ready = 1'b0;
        dispatch(4'd1, 32'h1, 32'h0, 32'h0, 4'd0, 4'd0, 4'd10);
        dispatch(4'd1, 32'h2, 32'h0, 32'h0, 4'd0, 4'd0, 4'd11);
        check("flush2_pre_count", 64'(count), 2);
        flush = 1'b1;
        dispatch(4'd1, 32'h3, 32'h0, 32'h0, 4'd0, 4'd0, 4'd12);
        flush = 1'b0;
        check("flush_empty_count", 64'(count), 0);
        ex_ready = 1'b1;
        repeat (3) step();
        expect_ex(4'd1, 32'h77, '0, 1'b0, 4'd13);
        dispatch(4'd1, 32'h70, 32'h0, 32'h7, 4'd0, 4'd0, 4'd13);
        step();
        check("flush_empty_reuse_count", 64'(count), 0);

        // rdy low freezes everything, including dispatch and issue.
        ex_ready = 1'b0;
        dispatch(4'd1, 32'h80, 32'h0, 32'h8, 4'd0, 4'd0, 4'd14);
        rdy = 1'b0;
        ex_ready = 1'b1;
        dsp_valid = 1'b1; dsp_rob = 4'd15;
        repeat (3) step();
        check("rdy_hold_count", 64'(count), 1);
        check("rdy_hold_ex_valid", 64'(ex_valid), 0);
        dsp_valid = 1'b0;
        expect_ex(4'd1, 32'h88, '0, 1'b0, 4'd14);
        rdy = 1'b1;
        step();
        step();
        check("rdy_resume_count", 64'(count), 0);

        // Streaming 3*DEPTH loads: insert and issue overlap, pointers wrap.
        ex_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            expect_ex(4'd1, DATA_W'(i * 257), '0, 1'b0, ROB_W'(i % 15 + 1));
            dsp_op = 4'd1; dsp_v1 = DATA_W'(i * 256); dsp_v2 = '0;
            dsp_imm = DATA_W'(i); dsp_q1 = '0; dsp_q2 = '0;
            dsp_rob = ROB_W'(i % 15 + 1);
            dsp_valid = 1'b1;
            step();
            check("stream_count", 64'(count), 1);
        end
        dsp_valid = 1'b0;
        step();
        step();
        check("stream_drained_count", 64'(count), 0);

        // Reset mid-stream overrides flush, rdy and dispatch.
        ex_ready = 1'b0;
        stq.push_back(4'd2);
        dispatch(4'd6, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd2);
        for (int i = 0; i < 4; i++)
            dispatch(4'd1, DATA_W'(i), 32'h0, 32'h0, 4'd0, 4'd0, ROB_W'(i + 3));
        check("pre_rst_count", 64'(count), 5);
        rst = 1'b1; flush = 1'b1; rdy = 1'b0; dsp_valid = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; rdy = 1'b1; dsp_valid = 1'b0;
        check("mid_rst_count", 64'(count), 0);
        check("mid_rst_full", 64'(full), 0);
        check("mid_rst_af", 64'(almost_full), 0);
        check("mid_rst_ex_valid", 64'(ex_valid), 0);
        check("mid_rst_st_req_valid", 64'(st_req_valid), 0);
        check("mid_rst_ex_rob", 64'(ex_rob), 0);
        check("mid_rst_st_req_rob", 64'(st_req_rob), 0);
        ex_ready = 1'b1;
        repeat (3) step();
        expect_ex(4'd1, 32'h99, '0, 1'b0, 4'd5);
        dispatch(4'd1, 32'h90, 32'h0, 32'h9, 4'd0, 4'd0, 4'd5);
        step();
        step();
        check("post_rst_count", 64'(count), 0);

        check("ex_queue_drained", 64'(exq.size()), 0);
        check("st_queue_drained", 64'(stq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ls_queue.md
LS_QUEUE -- requirements
Module: ls_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, queue entries; power of two, minimum 4.
REQ-002 SHALL have parameter ROB_W, default 4, ROB tag width; tag 0 means "no dependency".
REQ-003 SHALL have parameter DATA_W, default 32, operand, address and data width.
REQ-004 SHALL have parameter OP_W, default 4, opcode width; opcodes >= parameter ST_BASE (default 5) are stores, all others are loads.
REQ-005 SHALL have parameter AF_SLACK, default 2, almost-full margin.
REQ-006 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, synchronous active-high reset); reset is synchronous and active-high.
REQ-007 SHALL have port rdy (in, 1); when low, all state holds.
REQ-008 SHALL have dispatch inputs dsp_valid (1), dsp_op (OP_W), dsp_v1/dsp_v2/dsp_imm (DATA_W) and dsp_q1/dsp_q2/dsp_rob (ROB_W).
REQ-009 SHALL have outputs full (1), almost_full (1) and count ($clog2(DEPTH)+1).
REQ-010 SHALL have an issue channel: outputs ex_valid (1), ex_op (OP_W), ex_addr (DATA_W), ex_wdata (DATA_W), ex_rob (ROB_W); input ex_ready (1).
REQ-011 SHALL have CDB inputs cdb0_valid/cdb0_rob/cdb0_data and cdb1_valid/cdb1_rob/cdb1_data.
REQ-012 SHALL have commit inputs commit_valid (1) and commit_rob (ROB_W).
REQ-013 SHALL have outputs st_req_valid (1) and st_req_rob (ROB_W), requesting commit of the head store.
REQ-014 SHALL have input flush (1), the mispredict flush.

Function
REQ-015 SHALL implement a circular FIFO with head, tail and count registers; both pointers wrap from DEPTH-1 to 0.
REQ-016 SHALL drive full = (count==DEPTH) and almost_full = (count >= DEPTH-AF_SLACK), both combinational from registered count.
REQ-017 SHALL insert at tail when dsp_valid && !full; dsp_valid while full is ignored and state is unchanged.
REQ-018 SHALL, on insert, bypass a same-cycle matching CDB tag (cdb0 priority over cdb1) into V/Q, so the stored Q is 0.
REQ-019 SHALL, each cycle, replace V with data and clear Q to 0 in every busy entry whose nonzero Q matches a valid CDB tag.
REQ-020 SHALL mark an entry committed when commit_valid and its rob tag equals commit_rob.
REQ-021 SHALL issue the head entry when it is busy, q1==0, q2==0, ex_ready==1, and it is either a load or a committed store.
REQ-022 SHALL register issue results: ex_valid=1 for exactly one cycle, ex_addr=v1+imm (modulo 2^DATA_W), ex_wdata=v2 (don't-care for loads), ex_rob=tag; head advances.
REQ-023 SHALL, for an operand-ready uncommitted head store, pulse st_req_valid for one cycle with st_req_rob=tag; it is not repeated until that entry leaves the head.
REQ-024 SHALL update count by +1 on insert, -1 on issue, and leave it unchanged when both occur in the same cycle.
REQ-025 SHALL give an inserted entry an earliest issue cycle of insert+1.
REQ-026 SHALL make flush highest priority: discard all uncommitted entries, keep committed stores (contiguous from head), set tail=last kept+1 and recompute count; no insert, issue or st_req occurs that cycle and ex_valid=0.
REQ-027 SHALL, on flush with no committed stores, leave the queue empty with tail=head and count=0.
REQ-028 SHALL, when rdy=0, hold pointers, entries and outputs, except that ex_valid and st_req_valid drive 0.

Reset
REQ-029 SHALL, on rst=1 at a clk edge, set head=tail=0, count=0, all entries invalid, and all Q/commit flags cleared.
REQ-030 SHALL drive ex_valid=0, st_req_valid=0, st_req_rob=0 and ex_rob=0 out of reset; rst overrides flush and rdy, including mid-operation.

Verification
REQ-031 SHALL cover: insert load v1=0x100, imm=4, q=0, ex_ready=1 -> ex_valid one cycle later with ex_addr=0x104, count back to 0.
REQ-032 SHALL cover: insert DEPTH entries with ex_ready=0 -> full=1 and count=DEPTH; one extra dsp_valid is dropped; almost_full=1 from count=DEPTH-2.
REQ-033 SHALL cover: store with q2=3, then cdb1 rob=3 data=0xAB -> single st_req_rob pulse; commit -> issue with ex_wdata=0xAB.
REQ-034 SHALL cover: insert with dsp_q1=5 while cdb0 rob=5 is valid in the same cycle -> entry issues next cycle with v1 = cdb0 data.
REQ-035 SHALL cover: queue holds committed store, committed store, load, uncommitted store; assert flush -> count=2 and both stores issue in order.
REQ-036 SHALL cover: wrap-around across 3*DEPTH inserts/issues, and rst asserted mid-stream -> all state reset the next cycle.
